// File: rtl/nes_dma_pkg.sv
// nes_dma_pkg: state encoding, default register addresses and bus-phase constants for nes_dma_ctrl
//   dma_state_t       : controller states (IDLE, ALIGN, OAM_RD, OAM_WR, DMC_RD)
//   DEF_OAM_TRIG_ADDR : CPU write address that starts sprite DMA
//   DEF_OAM_DATA_ADDR : PPU OAM data port written by every sprite DMA put cycle
//   PHASE_GET/PUT     : values of the cycle-parity flop for read and write cycles
package nes_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        OAM_RD,
        OAM_WR,
        DMC_RD
    } dma_state_t;

    localparam logic [15:0] DEF_OAM_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] DEF_OAM_DATA_ADDR = 16'h2004;

    localparam logic PHASE_GET = 1'b0;
    localparam logic PHASE_PUT = 1'b1;

endpackage

// File: rtl/nes_dma_ctrl.sv
// nes_dma_ctrl: bus master shared by the 6502 core, sprite (OAM) DMA and DMC sample fetches
//   clk, b_rst                     : clock (one CPU cycle per edge), async active-low reset
//   cpu_addr_in/wdata_in/ren/wen   : core bus request
//   cpu_rdy                        : core ready; low stalls the core's read cycle
//   bus_addr/wdata/ren/wen, rdata  : system bus; read data valid in the cycle of bus_ren
//   dmc_req, dmc_addr              : level request for one DMC byte and its address
//   dmc_ack, dmc_data              : one-cycle pulse with the fetched DMC byte
//   busy                           : controller owns the bus
module nes_dma_ctrl
    import nes_dma_pkg::*;
#(
    parameter logic [15:0] OAM_TRIG_ADDR = DEF_OAM_TRIG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR
) (
    input  logic        clk,
    input  logic        b_rst,
    input  logic [15:0] cpu_addr_in,
    input  logic [7:0]  cpu_wdata_in,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic [7:0]  bus_rdata,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data,
    output logic        busy
);

    dma_state_t state;
    dma_state_t arb;
    logic       phase;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] oam_byte;
    logic       oam_pend;
    logic       dmc_pend;
    logic       trig;
    logic       halt;
    logic       oam_more;

    always_comb begin
        // the request level is still high while its ack is out; do not fetch twice
        dmc_pend  = dmc_req && !dmc_ack;
        trig      = state == IDLE && cpu_wen && cpu_addr_in == OAM_TRIG_ADDR;
        // only read cycles can be stalled through rdy, so writes always pass
        halt      = state == IDLE && cpu_ren && (oam_pend || dmc_pend);
        // the last OAM write clears oam_pend on this edge, so look ahead
        oam_more  = oam_pend && !(state == OAM_WR && idx == 8'hFF);
        arb       = dmc_pend ? DMC_RD : oam_more ? OAM_RD : IDLE;
        cpu_rdy   = state == IDLE && !halt;
        busy      = state != IDLE;
        bus_addr  = state == DMC_RD ? dmc_addr :
                    state == OAM_RD ? {page, idx} :
                    state == OAM_WR ? OAM_DATA_ADDR : cpu_addr_in;
        bus_wdata = state == OAM_WR ? oam_byte : cpu_wdata_in;
        bus_ren   = state == IDLE ? cpu_ren : (state == DMC_RD || state == OAM_RD);
        bus_wen   = state == IDLE ? cpu_wen : state == OAM_WR;
    end

    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            state    <= IDLE;
            phase    <= PHASE_GET;
            page     <= 8'h00;
            idx      <= 8'h00;
            oam_byte <= 8'h00;
            oam_pend <= 1'b0;
            dmc_ack  <= 1'b0;
            dmc_data <= 8'h00;
        end else begin
            phase   <= ~phase;
            dmc_ack <= state == DMC_RD;
            // a halt on a get cycle must burn one put cycle so reads land on get cycles
            case (state)
                IDLE:    if (halt) state <= (phase == PHASE_PUT) ? (dmc_pend ? DMC_RD : OAM_RD) : ALIGN;
                ALIGN:   state <= arb;
                OAM_RD:  state <= OAM_WR;
                OAM_WR:  state <= arb;
                DMC_RD:  state <= oam_pend ? ALIGN : IDLE;
                default: state <= IDLE;
            endcase
            if (trig) begin
                page     <= cpu_wdata_in;
                idx      <= 8'h00;
                oam_pend <= 1'b1;
            end
            if (state == DMC_RD)
                dmc_data <= bus_rdata;
            if (state == OAM_RD)
                oam_byte <= bus_rdata;
            if (state == OAM_WR) begin
                idx <= idx + 8'd1;
                if (idx == 8'hFF)
                    oam_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nes_dma_ctrl.sv
// tb_nes_dma_ctrl: self-checking bench for nes_dma_ctrl (idle pass-through table, OAM/DMC transfers, reset abort)
module tb_nes_dma_ctrl;

    logic        clk = 1'b0;
    logic        b_rst = 1'b0;
    logic [15:0] cpu_addr_in = 16'h0;
    logic [7:0]  cpu_wdata_in = 8'h0;
    logic        cpu_ren = 1'b0;
    logic        cpu_wen = 1'b0;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ren;
    logic        bus_wen;
    logic [7:0]  bus_rdata;
    logic        dmc_req = 1'b0;
    logic [15:0] dmc_addr = 16'h0;
    logic        dmc_ack;
    logic [7:0]  dmc_data;
    logic        busy;

    logic [7:0]  mem [0:65535];
    int          tests = 0;
    int          fails = 0;
    int          cyc;
    logic        tb_phase;

    nes_dma_ctrl dut (
        .clk(clk), .b_rst(b_rst),
        .cpu_addr_in(cpu_addr_in), .cpu_wdata_in(cpu_wdata_in),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_rdy(cpu_rdy),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ren(bus_ren), .bus_wen(bus_wen),
        .bus_rdata(bus_rdata),
        .dmc_req(dmc_req), .dmc_addr(dmc_addr), .dmc_ack(dmc_ack), .dmc_data(dmc_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign bus_rdata = mem[bus_addr];

    // cycle parity since reset release: even = get cycle, odd = put cycle
    always @(posedge clk or negedge b_rst)
        if (!b_rst) cyc <= 0;
        else cyc <= cyc + 1;
    assign tb_phase = cyc[0];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        r;
        logic        w;
        logic [27:0] exp;  // {bus_addr, bus_wdata, bus_ren, bus_wen, cpu_rdy, busy}
    } vec_t;

    task automatic dmc_xfer(input logic [15:0] a, input logic hph);
        logic [15:0] rq[$];
        int          stall = 0;
        int          acks = 0;
        int          viol = 0;
        logic [7:0]  ad = 8'h0;
        bit          done = 0;
        do begin
            @(posedge clk); #1;
            cpu_ren = 1'b0;
            cpu_wen = 1'b0;
        end while (tb_phase != hph);
        cpu_ren = 1'b1;
        cpu_addr_in = 16'h8123;
        dmc_req = 1'b1;
        dmc_addr = a;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (busy && bus_ren) begin
                rq.push_back(bus_addr);
                if (tb_phase != 1'b0) viol++;
            end
            if (dmc_ack) begin
                acks++;
                ad = dmc_data;
                dmc_req = 1'b0;
            end
            if (cpu_rdy) done = 1;
            else begin
                stall++;
                @(posedge clk); #1;
            end
        end
        chk("dmc_done", 32'(done), 1);
        chk("dmc_stall", stall, hph ? 2 : 3);
        chk("dmc_acks", acks, 1);
        chk("dmc_data", ad, mem[a]);
        chk("dmc_rd_count", rq.size(), 1);
        chk("dmc_rd_addr", rq.size() > 0 ? 32'(rq[0]) : 32'hFFFF_FFFF, a);
        chk("dmc_get_phase", viol, 0);
        cpu_ren = 1'b0;
        @(negedge clk);
        chk("dmc_ack_pulse", dmc_ack, 0);
    endtask

    // steal_at: -1 none, 0 DMC raised with the trigger, k>0 raised after k OAM writes
    // abort_at: -1 none, else reset asserted once that many OAM writes were seen
    task automatic oam_xfer(input logic [7:0] pg, input logic hph, input int nwr,
                            input int steal_at, input int abort_at);
        logic [15:0] rq[$];
        logic [7:0]  wd[$];
        logic [15:0] er[$];
        int          stall = 0;
        int          viol = 0;
        int          acks = 0;
        int          bad = 0;
        logic [7:0]  ad = 8'h0;
        bit          inj = 0;
        bit          done = 0;
        @(posedge clk); #1;
        cpu_ren = 1'b0;
        cpu_wen = 1'b1;
        cpu_addr_in = 16'h4014;
        cpu_wdata_in = pg;
        if (steal_at == 0) begin
            dmc_req = 1'b1;
            dmc_addr = 16'hC000;
            inj = 1;
        end
        for (int i = 0; i < nwr; i++) begin
            @(posedge clk); #1;
            cpu_addr_in = 16'h0300 + 16'(i);
            cpu_wdata_in = 8'(i);
            @(negedge clk);
            chk("wr_no_halt", {busy, cpu_rdy, bus_wen}, 3'b011);
        end
        do begin
            @(posedge clk); #1;
            cpu_wen = 1'b0;
        end while (tb_phase != hph);
        cpu_ren = 1'b1;
        cpu_addr_in = 16'h8000;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (busy && bus_ren) begin
                rq.push_back(bus_addr);
                if (tb_phase != 1'b0) viol++;
            end
            if (bus_wen) begin
                wd.push_back(bus_wdata);
                if (bus_addr !== 16'h2004 || tb_phase != 1'b1) viol++;
            end
            if (dmc_ack) begin
                acks++;
                ad = dmc_data;
                dmc_req = 1'b0;
            end
            if (abort_at >= 0 && wd.size() == abort_at) begin
                #2 b_rst = 1'b0;
                #1;
                chk("rst_rdy", cpu_rdy, 1);
                chk("rst_busy", busy, 0);
                chk("rst_ack", dmc_ack, 0);
                chk("rst_dmc_data", dmc_data, 0);
                chk("rst_bus_mirror", {bus_addr, bus_ren, bus_wen}, {cpu_addr_in, cpu_ren, cpu_wen});
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_no_write", {bus_wen, busy}, 0);
                end
                b_rst = 1'b1;
                done = 1;
            end else if (cpu_rdy) done = 1;
            else begin
                stall++;
                @(posedge clk); #1;
                if (steal_at > 0 && !inj && wd.size() == steal_at) begin
                    dmc_req = 1'b1;
                    dmc_addr = 16'hC000;
                    inj = 1;
                end
            end
        end
        cpu_ren = 1'b0;
        chk("oam_done", 32'(done), 1);
        if (abort_at >= 0) return;
        // reference: 256 ascending page reads, the DMC read slotted before the next OAM read
        for (int i = 0; i < 256; i++) er.push_back({pg, 8'(i)});
        if (steal_at >= 0) er.insert(steal_at == 0 ? 0 : steal_at + 1, 16'hC000);
        chk("oam_stall", stall, (hph ? 513 : 514) + (steal_at >= 0 ? 2 : 0));
        chk("oam_rd_count", rq.size(), er.size());
        for (int i = 0; i < rq.size() && i < er.size(); i++)
            if (rq[i] !== er[i]) bad++;
        chk("oam_rd_seq", bad, 0);
        chk("oam_wr_count", wd.size(), 256);
        bad = 0;
        for (int i = 0; i < wd.size() && i < 256; i++)
            if (wd[i] !== mem[{pg, 8'(i)}]) bad++;
        chk("oam_wr_data", bad, 0);
        chk("oam_phase", viol, 0);
        if (steal_at >= 0) begin
            chk("steal_acks", acks, 1);
            chk("steal_data", ad, mem[16'hC000]);
        end
    endtask

    initial begin
        vec_t        vt[6];
        logic [15:0] ra;
        logic [7:0]  rd;
        logic        rr, rw;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'hC000] = 8'hA5;

        vt[0] = '{16'h0000, 8'h00, 1'b0, 1'b0, {16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}};
        vt[1] = '{16'h8000, 8'h11, 1'b1, 1'b0, {16'h8000, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0}};
        vt[2] = '{16'h4014, 8'h02, 1'b1, 1'b0, {16'h4014, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0}};
        vt[3] = '{16'h4015, 8'h0F, 1'b0, 1'b1, {16'h4015, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0}};
        vt[4] = '{16'h2004, 8'h5A, 1'b0, 1'b1, {16'h2004, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0}};
        vt[5] = '{16'hFFFF, 8'hFF, 1'b1, 1'b0, {16'hFFFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0}};

        cpu_addr_in = 16'h1234;
        cpu_ren = 1'b1;
        #12;
        chk("reset_rdy", cpu_rdy, 1);
        chk("reset_busy", busy, 0);
        chk("reset_ack", dmc_ack, 0);
        chk("reset_dmc_data", dmc_data, 0);
        chk("reset_mirror", {bus_addr, bus_ren, bus_wen}, {16'h1234, 1'b1, 1'b0});
        @(negedge clk);
        b_rst = 1'b1;
        cpu_ren = 1'b0;

        foreach (vt[i]) begin
            @(posedge clk); #1;
            cpu_addr_in = vt[i].a;
            cpu_wdata_in = vt[i].d;
            cpu_ren = vt[i].r;
            cpu_wen = vt[i].w;
            @(negedge clk);
            chk("idle_vec", {bus_addr, bus_wdata, bus_ren, bus_wen, cpu_rdy, busy}, vt[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            if (ra == 16'h4014) ra = 16'h4015;
            rd = 8'($urandom);
            rr = 1'($urandom);
            rw = 1'($urandom);
            @(posedge clk); #1;
            cpu_addr_in = ra;
            cpu_wdata_in = rd;
            cpu_ren = rr;
            cpu_wen = rw;
            @(negedge clk);
            chk("idle_rand", {bus_addr, bus_wdata, bus_ren, bus_wen, cpu_rdy, busy},
                {ra, rd, rr, rw, 1'b1, 1'b0});
        end
        @(posedge clk); #1;
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;

        oam_xfer(8'h02, 1'b1, 0, -1, -1);
        oam_xfer(8'h02, 1'b0, 0, -1, -1);
        oam_xfer(8'h05, 1'b1, 2, -1, -1);
        dmc_xfer(16'hC000, 1'b1);
        dmc_xfer(16'hC000, 1'b0);
        dmc_xfer(16'($urandom), 1'($urandom));
        oam_xfer(8'h03, 1'b1, 0, 128, -1);
        oam_xfer(8'($urandom), 1'b0, 0, 128, -1);
        oam_xfer(8'h06, 1'b1, 0, 0, -1);
        oam_xfer(8'h07, 1'b1, 0, -1, 40);
        oam_xfer(8'h08, 1'b0, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
